// File: rtl/lidar_pkg.sv
// Shared types and helpers for the LiDAR point unpacker: batch/point geometry,
// the per-point payload struct, the unpacker FSM state type and mask helpers.
package lidar_pkg;

  localparam int unsigned N_POINTS = 4;
  localparam int unsigned POINT_W  = 128;
  localparam int unsigned BATCH_W  = N_POINTS * POINT_W;
  localparam int unsigned COORD_W  = 32;
  localparam int unsigned IDX_W    = $clog2(N_POINTS);

  // One decoded point; x occupies the least significant 32 bits.
  typedef struct packed {
    logic [COORD_W-1:0] attr;
    logic [COORD_W-1:0] z;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } point_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } unpack_state_e;

  typedef logic [N_POINTS-1:0] pt_mask_t;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [IDX_W-1:0] lowest_idx(input pt_mask_t m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_POINTS - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic pt_mask_t clear_lowest(input pt_mask_t m);
    return m & (m - pt_mask_t'(1));
  endfunction

  function automatic point_t get_point(input logic [BATCH_W-1:0] b,
                                       input logic [IDX_W-1:0] idx);
    return point_t'(b[POINT_W*idx +: POINT_W]);
  endfunction

endpackage

// File: rtl/lidar_batch_fifo.sv
// Synchronous first-word-fall-through batch FIFO.
// Ports: push/push_data write side, pop/head read side (head valid while !empty),
// full/empty flags and level (occupied entries). A push while full is accepted
// when a pop happens in the same cycle.
module lidar_batch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointer/count update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != LW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;

endmodule

// File: rtl/lidar_point_unpacker.sv
// Captures 512-bit LiDAR batches (4 points) from the decoder, buffers them in a
// batch FIFO and serialises each batch into per-point valid/ready records.
// Ports: in_valid/in_data/in_error (decoder side, no backpressure);
// pt_valid/pt_ready/pt_x/pt_y/pt_z/pt_attr/pt_idx/pt_last (point stream);
// fifo_level, overflow (sticky), drop_count (saturating), busy (status).
// Optional macro LIDAR_UNPACK_RANGE_FILTER_EN suppresses points whose |x|,|y|
// or |z| exceeds RANGE_MAX.
module lidar_point_unpacker
  import lidar_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
`ifdef LIDAR_UNPACK_RANGE_FILTER_EN
  ,
  parameter logic [31:0] RANGE_MAX = 32'd100000
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [BATCH_W-1:0]            in_data,
  input  logic                          in_error,
  output logic                          pt_valid,
  input  logic                          pt_ready,
  output logic [COORD_W-1:0]            pt_x,
  output logic [COORD_W-1:0]            pt_y,
  output logic [COORD_W-1:0]            pt_z,
  output logic [COORD_W-1:0]            pt_attr,
  output logic [IDX_W-1:0]              pt_idx,
  output logic                          pt_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic                          busy
);

  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DROP_W = 16;

  unpack_state_e       state_q, state_d;
  logic [BATCH_W-1:0]  shadow_q, shadow_d;
  pt_mask_t            mask_q, mask_d;
  point_t              pt_q, pt_d;
  logic [IDX_W-1:0]    pt_idx_q, pt_idx_d;
  logic                pt_last_q, pt_last_d;
  logic                pt_valid_q, pt_valid_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;
  logic                busy_q, busy_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BATCH_W-1:0]  fifo_head;
  logic [LVL_W-1:0]    level_nxt;
  logic                hs, load, ovf_drop, drop;
  pt_mask_t            remain, load_mask;

  lidar_batch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BATCH_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

`ifdef LIDAR_UNPACK_RANGE_FILTER_EN
  // Signed magnitude check; 32'h80000000 falls below -RANGE_MAX.
  function automatic logic coord_ok(input logic [COORD_W-1:0] v);
    logic signed [COORD_W-1:0] s;
    s = $signed(v);
    return (s <= $signed(RANGE_MAX)) && (s >= -$signed(RANGE_MAX));
  endfunction
`endif

  // Points that survive loading of the FIFO head batch.
  always_comb begin
    load_mask = '1;
`ifdef LIDAR_UNPACK_RANGE_FILTER_EN
    for (int i = 0; i < N_POINTS; i++) begin
      load_mask[i] = coord_ok(fifo_head[POINT_W*i      +: COORD_W]) &&
                     coord_ok(fifo_head[POINT_W*i + 32 +: COORD_W]) &&
                     coord_ok(fifo_head[POINT_W*i + 64 +: COORD_W]);
    end
`endif
  end

  // FSM next state and registered point outputs. mask_q holds the points not
  // yet accepted, including the one currently presented.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    mask_d     = mask_q;
    pt_d       = pt_q;
    pt_idx_d   = pt_idx_q;
    pt_last_d  = pt_last_q;
    pt_valid_d = pt_valid_q;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    hs         = pt_valid_q && pt_ready;
    remain     = hs ? clear_lowest(mask_q) : mask_q;

    case (state_q)
      ST_IDLE: load = !fifo_empty;
      ST_EMIT: begin
        if (remain == '0) begin
          // Batch finished (or fully filtered): reload without a bubble.
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            mask_d     = '0;
            pt_valid_d = 1'b0;
            pt_last_d  = 1'b0;
          end
        end else if (hs) begin
          mask_d    = remain;
          pt_idx_d  = lowest_idx(remain);
          pt_d      = get_point(shadow_q, pt_idx_d);
          pt_last_d = (clear_lowest(remain) == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      fifo_pop   = 1'b1;
      state_d    = ST_EMIT;
      shadow_d   = fifo_head;
      mask_d     = load_mask;
      pt_idx_d   = lowest_idx(load_mask);
      pt_d       = get_point(fifo_head, pt_idx_d);
      pt_last_d  = (clear_lowest(load_mask) == '0);
      pt_valid_d = |load_mask;
    end
  end

  // Write admission, drop accounting and status.
  always_comb begin
    ovf_drop     = in_valid && !in_error && fifo_full && !fifo_pop;
    drop         = (in_valid && in_error) || ovf_drop;
    fifo_push    = in_valid && !in_error && !ovf_drop;
    overflow_d   = overflow_q || ovf_drop;
    drop_count_d = (drop && (drop_count_q != '1)) ? drop_count_q + DROP_W'(1)
                                                  : drop_count_q;
    level_nxt    = fifo_level + LVL_W'(fifo_push) - LVL_W'(fifo_pop);
    busy_d       = (state_d == ST_EMIT) || (level_nxt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      mask_q       <= '0;
      pt_q         <= '0;
      pt_idx_q     <= '0;
      pt_last_q    <= 1'b0;
      pt_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      mask_q       <= mask_d;
      pt_q         <= pt_d;
      pt_idx_q     <= pt_idx_d;
      pt_last_q    <= pt_last_d;
      pt_valid_q   <= pt_valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      busy_q       <= busy_d;
    end
  end

  assign pt_valid   = pt_valid_q;
  assign pt_x       = pt_q.x;
  assign pt_y       = pt_q.y;
  assign pt_z       = pt_q.z;
  assign pt_attr    = pt_q.attr;
  assign pt_idx     = pt_idx_q;
  assign pt_last    = pt_last_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lidar_point_unpacker.sv
// Scoreboard bench for lidar_point_unpacker: stimulus pushes expected point
// records, a negedge monitor pops and compares on every handshake and checks
// output stability during stalls.
module tb_lidar_point_unpacker;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [511:0] in_data = '0;
  logic         in_error = 1'b0;
  logic         pt_ready;
  logic         ready_fixed = 1'b0;
  logic         rand_mode = 1'b0;
  logic         rnd_ready = 1'b0;
  logic         pt_valid, pt_last, overflow, busy;
  logic [31:0]  pt_x, pt_y, pt_z, pt_attr;
  logic [1:0]   pt_idx;
  logic [2:0]   fifo_level;
  logic [15:0]  drop_count;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] attr;
    logic [1:0]  idx;
    logic        last;
  } rec_t;

  rec_t sb[$];
  rec_t cur, prev, exp_r;
  bit   prev_stall = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   hs_total = 0;
  int   hs_at[4096];
  int   exp_drop = 0;
  int   h0, c0;

  lidar_point_unpacker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_error   (in_error),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .pt_x       (pt_x),
    .pt_y       (pt_y),
    .pt_z       (pt_z),
    .pt_attr    (pt_attr),
    .pt_idx     (pt_idx),
    .pt_last    (pt_last),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .busy       (busy)
  );

  assign pt_ready = rand_mode ? rnd_ready : ready_fixed;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1 rnd_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: compare each accepted record and check stall stability.
  always @(negedge clk) begin
    cur = {pt_x, pt_y, pt_z, pt_attr, pt_idx, pt_last};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 160'(pt_valid), 160'd1);
        check("stall_hold", 160'(cur), 160'(prev));
      end
      if (pt_valid && pt_ready) begin
        if (hs_total < 4096) hs_at[hs_total] = cyc;
        hs_total++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record: got idx %0d x %0h with empty scoreboard", pt_idx, pt_x);
        end else begin
          exp_r = sb.pop_front();
          check("record", 160'(cur), 160'(exp_r));
        end
      end
      prev_stall = pt_valid && !pt_ready;
      prev = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [511:0] d, input bit err);
    in_valid = 1'b1;
    in_data  = d;
    in_error = err;
    tick();
    in_valid = 1'b0;
    in_error = 1'b0;
  endtask

  // Push the expected records of batch d for the surviving points in m.
  task automatic expect_batch(input logic [511:0] d, input logic [3:0] m);
    rec_t r;
    logic [3:0] hi;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        hi     = m >> (i + 1);
        r.x    = d[128*i      +: 32];
        r.y    = d[128*i + 32 +: 32];
        r.z    = d[128*i + 64 +: 32];
        r.attr = d[128*i + 96 +: 32];
        r.idx  = 2'(i);
        r.last = (hi == 4'd0);
        sb.push_back(r);
      end
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 160'(sb.size()), 160'd0);
    tick();
    tick();
    check({name, "_idle_valid"}, 160'(pt_valid), 160'd0);
    check({name, "_idle_busy"}, 160'(busy), 160'd0);
  endtask

  function automatic logic [127:0] pt(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z, input logic [31:0] a);
    return {a, z, y, x};
  endfunction

  function automatic logic [511:0] mk(input int k);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 4; i++)
      d[128*i +: 128] = pt(32'(k*4 + i), 32'(-(k*4 + i) - 7), 32'(i*1000 + k),
                           32'hC0DE0000 | 32'(k*16 + i));
    return d;
  endfunction

  task automatic check_zero(input string name);
    check({name, "_valid"}, 160'(pt_valid), 160'd0);
    check({name, "_idx"}, 160'(pt_idx), 160'd0);
    check({name, "_x"}, 160'(pt_x), 160'd0);
    check({name, "_last"}, 160'(pt_last), 160'd0);
    check({name, "_level"}, 160'(fifo_level), 160'd0);
    check({name, "_ovf"}, 160'(overflow), 160'd0);
    check({name, "_drop"}, 160'(drop_count), 160'd0);
    check({name, "_busy"}, 160'(busy), 160'd0);
  endtask

  initial begin
    logic [511:0] d;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // T1: single batch, ready high, latency and back-to-back points
    ready_fixed = 1'b1;
    for (int i = 0; i < 4; i++)
      d[128*i +: 128] = pt(32'(i + 1), 32'(-(i + 1)), 32'd0, 32'hA0B0C0D0 + 32'(i));
    expect_batch(d, 4'hF);
    h0 = hs_total;
    c0 = cyc;
    send(d, 1'b0);
    wait_drain("t1_drain", 20);
    check("t1_latency", 160'(hs_at[h0]), 160'(c0 + 2));
    check("t1_span", 160'(hs_at[h0 + 3] - hs_at[h0]), 160'd3);

    // T2: fill while stalled, then overflow, then release
    ready_fixed = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_batch(mk(10 + k), 4'hF);
      send(mk(10 + k), 1'b0);
    end
    check("t2_level3", 160'(fifo_level), 160'd3);
    check("t2_busy", 160'(busy), 160'd1);
    expect_batch(mk(14), 4'hF);
    send(mk(14), 1'b0);
    check("t2_level4", 160'(fifo_level), 160'd4);
    check("t2_no_ovf", 160'(overflow), 160'd0);
    send(mk(15), 1'b0);
    exp_drop++;
    check("t2_ovf", 160'(overflow), 160'd1);
    check("t2_drop", 160'(drop_count), 160'(exp_drop));
    check("t2_level_full", 160'(fifo_level), 160'd4);
    h0 = hs_total;
    ready_fixed = 1'b1;
    wait_drain("t2_drain", 60);
    check("t2_span", 160'(hs_at[h0 + 19] - hs_at[h0]), 160'd19);

    // T3: error-flagged batch is discarded
    send(mk(20), 1'b1);
    exp_drop++;
    tick();
    tick();
    tick();
    check("t3_drop", 160'(drop_count), 160'(exp_drop));
    check("t3_level", 160'(fifo_level), 160'd0);
    check("t3_valid", 160'(pt_valid), 160'd0);
    check("t3_ovf_sticky", 160'(overflow), 160'd1);

    // T4: 100 batches with random ready
    rand_mode = 1'b1;
    for (int k = 0; k < 100; k++) begin
      n = 0;
      while (sb.size() > 8 && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) check("t4_progress", 160'(sb.size()), 160'd8);
      expect_batch(mk(100 + k), 4'hF);
      send(mk(100 + k), 1'b0);
    end
    wait_drain("t4_drain", 2000);
    rand_mode = 1'b0;
    check("t4_drop", 160'(drop_count), 160'(exp_drop));

    // T5: reset mid-batch after idx 1 accepted
    ready_fixed = 1'b0;
    expect_batch(mk(300), 4'hF);
    send(mk(300), 1'b0);
    send(mk(301), 1'b0);
    n = 0;
    while (!pt_valid && n < 10) begin
      tick();
      n++;
    end
    check("t5_valid_seen", 160'(pt_valid), 160'd1);
    ready_fixed = 1'b1;
    tick();
    tick();
    ready_fixed = 1'b0;
    check("t5_idx2", 160'(pt_idx), 160'd2);
    check("t5_level_pre", 160'(fifo_level), 160'd1);
    rst_n = 1'b0;
    #1;
    check_zero("t5_reset");
    sb.delete();
    exp_drop = 0;
    tick();
    rst_n = 1'b1;
    tick();
    ready_fixed = 1'b1;
    expect_batch(mk(302), 4'hF);
    send(mk(302), 1'b0);
    wait_drain("t5_drain", 20);

`ifdef LIDAR_UNPACK_RANGE_FILTER_EN
    // T6: range filter, boundary values kept, out-of-range points skipped
    d[127:0]   = pt(32'd100000, 32'd1, 32'd2, 32'h11111111);
    d[255:128] = pt(32'd200000, 32'd3, 32'd4, 32'h22222222);
    d[383:256] = pt(32'd5, 32'hFFFE7960, 32'd6, 32'h33333333);
    d[511:384] = pt(32'd200000, 32'd7, 32'd8, 32'h44444444);
    expect_batch(d, 4'b0101);
    send(d, 1'b0);
    wait_drain("t6_drain", 20);
    d[127:0]   = pt(32'h80000000, 32'd0, 32'd0, 32'h55555555);
    d[255:128] = pt(32'd0, 32'd100001, 32'd0, 32'h66666666);
    d[383:256] = pt(32'd0, 32'd0, 32'hFFFE795F, 32'h77777777);
    d[511:384] = pt(32'hFFFCF2C0, 32'd0, 32'd0, 32'h88888888);
    send(d, 1'b0);
    repeat (4) tick();
    check("t6_all_filtered_valid", 160'(pt_valid), 160'd0);
    check("t6_all_filtered_drop", 160'(drop_count), 160'(exp_drop));
    check("t6_all_filtered_busy", 160'(busy), 160'd0);
    expect_batch(mk(400), 4'hF);
    send(mk(400), 1'b0);
    wait_drain("t6_after", 20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
